// File: rtl/icache_refill.sv
// Instruction-cache refill engine: fetches one missing word from memory and writes it into the icache.
// Optional sequential-word prefetch is enabled by defining ICACHE_REFILL_PREFETCH_EN.
module icache_refill (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        miss_valid,
   input  logic [31:0] miss_pc,
   input  logic        flush,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata,
   output logic        cache_we,
   output logic [31:0] cache_wpc,
   output logic [31:0] cache_winst,
   output logic        refill_done,
   output logic [31:0] refill_inst,
   output logic        busy,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      WR   = 2'd3
   } state_t;

   state_t      state;
   state_t      state_nx;
   logic [31:0] pc_reg;
   logic [31:0] data_reg;
   logic        cancel;
   logic        pf_phase;

   // Handshake: inst_req stays high in REQ until the cycle inst_addr_ok is seen;
   // exactly one data beat (inst_data_ok) is then expected while in WAIT.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (miss_valid && !flush) state_nx = REQ;
         REQ: begin
            if (inst_addr_ok)  state_nx = WAIT;
            else if (flush)    state_nx = IDLE;
         end
         WAIT: if (inst_data_ok) state_nx = (cancel || flush) ? IDLE : WR;
`ifdef ICACHE_REFILL_PREFETCH_EN
         WR: state_nx = (!pf_phase && !flush) ? REQ : IDLE;
`else
         WR: state_nx = IDLE;
`endif
         default: state_nx = IDLE;
      endcase
   end

   // An accepted request that gets flushed still owes us a data beat; cancel absorbs it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_reg   <= 32'd0;
         data_reg <= 32'd0;
         cancel   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (miss_valid && !flush) begin
                  pc_reg <= miss_pc;
                  cancel <= 1'b0;
               end
            end
            REQ: if (inst_addr_ok && flush) cancel <= 1'b1;
            WAIT: begin
               if (flush)        cancel   <= 1'b1;
               if (inst_data_ok) data_reg <= inst_rdata;
            end
`ifdef ICACHE_REFILL_PREFETCH_EN
            WR: begin
               if (!pf_phase && !flush) begin
                  pc_reg <= pc_reg + 32'd4;
                  cancel <= 1'b0;
               end
            end
`endif
            default: ;
         endcase
      end
   end

`ifdef ICACHE_REFILL_PREFETCH_EN
   // Marks that the word in flight is the sequential prefetch, not the demand word.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pf_phase <= 1'b0;
      end else if (state == IDLE && miss_valid && !flush) begin
         pf_phase <= 1'b0;
      end else if (state == WR && !pf_phase && !flush) begin
         pf_phase <= 1'b1;
      end
   end
`else
   assign pf_phase = 1'b0;
`endif

   always_comb begin
      inst_req    = 1'b0;
      inst_addr   = 32'd0;
      cache_we    = 1'b0;
      cache_wpc   = 32'd0;
      cache_winst = 32'd0;
      refill_done = 1'b0;
      refill_inst = 32'd0;
      busy        = (state != IDLE);
      state_dbg   = state;
      case (state)
         REQ: begin
            inst_req  = 1'b1;
            inst_addr = pc_reg;
         end
         WR: begin
            cache_we    = 1'b1;
            cache_wpc   = pc_reg;
            cache_winst = data_reg;
            if (!flush && !pf_phase) begin
               refill_done = 1'b1;
               refill_inst = data_reg;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_icache_refill.sv
// Directed, table-driven bench for icache_refill: one table row per clock cycle,
// plus a hand-written sequence counting cache writes per miss.
module tb_icache_refill;

   logic        clk;
   logic        rst_n;
   logic        miss_valid;
   logic [31:0] miss_pc;
   logic        flush;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        cache_we;
   logic [31:0] cache_wpc;
   logic [31:0] cache_winst;
   logic        refill_done;
   logic [31:0] refill_inst;
   logic        busy;
   logic [1:0]  state_dbg;

   int checks = 0;
   int errors = 0;

   icache_refill dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .miss_valid   (miss_valid),
      .miss_pc      (miss_pc),
      .flush        (flush),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .inst_rdata   (inst_rdata),
      .cache_we     (cache_we),
      .cache_wpc    (cache_wpc),
      .cache_winst  (cache_winst),
      .refill_done  (refill_done),
      .refill_inst  (refill_inst),
      .busy         (busy),
      .state_dbg    (state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One row = inputs applied for one cycle and the outputs expected during that cycle.
   typedef struct {
      string       name;
      logic        rst_n;
      logic        mv;
      logic [31:0] pc;
      logic        fl;
      logic        aok;
      logic        dok;
      logic [31:0] rd;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_we;
      logic [31:0] e_wpc;
      logic [31:0] e_winst;
      logic        e_done;
      logic [31:0] e_rinst;
      logic        e_busy;
   } vec_t;

   vec_t vec_q[$];

   task automatic chk(input string nm, input int row, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d actual=%h required=%h", nm, row, act, exp);
      end
   endtask

   task automatic add(input string nm, input logic r, input logic mv, input logic [31:0] pc,
                      input logic fl, input logic aok, input logic dok, input logic [31:0] rd,
                      input logic e_req, input logic [31:0] e_addr, input logic e_we,
                      input logic [31:0] e_wpc, input logic [31:0] e_winst,
                      input logic e_done, input logic [31:0] e_rinst, input logic e_busy);
      vec_t v;
      v.name = nm; v.rst_n = r; v.mv = mv; v.pc = pc; v.fl = fl; v.aok = aok; v.dok = dok;
      v.rd = rd; v.e_req = e_req; v.e_addr = e_addr; v.e_we = e_we; v.e_wpc = e_wpc;
      v.e_winst = e_winst; v.e_done = e_done; v.e_rinst = e_rinst; v.e_busy = e_busy;
      vec_q.push_back(v);
   endtask

   // Idle cycle: all outputs expected low.
   task automatic t_idle(input string nm, input logic r, input logic mv, input logic [31:0] pc,
                         input logic fl, input logic aok, input logic dok, input logic [31:0] rd);
      add(nm, r, mv, pc, fl, aok, dok, rd, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic t_req(input string nm, input logic fl, input logic aok, input logic [31:0] a);
      add(nm, 1, 0, 0, fl, aok, 0, 0, 1, a, 0, 0, 0, 0, 0, 1);
   endtask

   task automatic t_wait(input string nm, input logic r, input logic mv, input logic fl,
                         input logic aok, input logic dok, input logic [31:0] rd);
      add(nm, r, mv, 32'hDEAD_0000, fl, aok, dok, rd, 0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   task automatic t_wr(input string nm, input logic fl, input logic [31:0] wpc,
                       input logic [31:0] winst, input logic done);
      add(nm, 1, 0, 0, fl, 0, 0, 0, 0, 0, 1, wpc, winst, done, done ? winst : 32'd0, 1);
   endtask

   task automatic drive_idle();
      miss_valid = 0; miss_pc = 0; flush = 0;
      inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = 0;
   endtask

   task automatic build_table();
      t_idle("reset_state", 1, 0, 0, 0, 0, 0, 0);
`ifndef ICACHE_REFILL_PREFETCH_EN
      // Zero-wait refill.
      t_idle("zw_miss", 1, 1, 32'h1C00_0000, 0, 0, 0, 0);
      t_req ("zw_req", 0, 1, 32'h1C00_0000);
      t_wait("zw_wait", 1, 0, 0, 0, 1, 32'h0280_0C0C);
      t_wr  ("zw_wr", 0, 32'h1C00_0000, 32'h0280_0C0C, 1);
      t_idle("zw_idle", 1, 0, 0, 0, 0, 0, 0);
      // Stalled memory; miss_valid and stray addr_ok ignored while busy.
      t_idle("st_miss", 1, 1, 32'h0000_1000, 0, 0, 0, 0);
      t_req ("st_req0", 0, 0, 32'h0000_1000);
      add   ("st_req1", 1, 1, 32'hDEAD_0000, 0, 0, 0, 0, 1, 32'h0000_1000, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) t_req("st_reqn", 0, 0, 32'h0000_1000);
      t_req ("st_req_ok", 0, 1, 32'h0000_1000);
      t_wait("st_wait0", 1, 1, 0, 1, 0, 0);
      t_wait("st_wait1", 1, 0, 0, 0, 0, 0);
      t_wait("st_data", 1, 0, 0, 0, 1, 32'hAAAA_5555);
      t_wr  ("st_wr", 0, 32'h0000_1000, 32'hAAAA_5555, 1);
      t_idle("st_late_dok", 1, 0, 0, 0, 0, 1, 32'h1234_5678);
      t_idle("st_late_aok", 1, 0, 0, 0, 1, 0, 0);
      // Flush in WAIT, then a fresh miss completes normally.
      t_idle("fw_miss", 1, 1, 32'h0000_2000, 0, 0, 0, 0);
      t_req ("fw_req", 0, 1, 32'h0000_2000);
      t_wait("fw_flush", 1, 0, 1, 0, 0, 0);
      t_wait("fw_absorb", 1, 0, 0, 0, 1, 32'h1111_1111);
      t_idle("fw_remiss", 1, 1, 32'h0000_3000, 0, 0, 0, 0);
      t_req ("fw_req2", 0, 1, 32'h0000_3000);
      t_wait("fw_data2", 1, 0, 0, 0, 1, 32'h3333_3333);
      t_wr  ("fw_wr2", 0, 32'h0000_3000, 32'h3333_3333, 1);
      t_idle("fw_idle", 1, 0, 0, 0, 0, 0, 0);
      // Flush in REQ together with addr_ok: request is out, data absorbed.
      t_idle("fa_miss", 1, 1, 32'h0000_6000, 0, 0, 0, 0);
      t_req ("fa_req", 1, 1, 32'h0000_6000);
      t_wait("fa_wait", 1, 0, 0, 0, 0, 0);
      t_wait("fa_data", 1, 0, 0, 0, 1, 32'h6666_6666);
      t_idle("fa_idle", 1, 0, 0, 0, 0, 0, 0);
`else
      // Prefetch: demand word at the top of memory wraps to 0 for the sequential word.
      t_idle("pf_miss", 1, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
      t_req ("pf_req", 0, 1, 32'hFFFF_FFFC);
      t_wait("pf_data", 1, 0, 0, 0, 1, 32'hA0A0_A0A0);
      t_wr  ("pf_wr", 0, 32'hFFFF_FFFC, 32'hA0A0_A0A0, 1);
      t_req ("pf_req2", 0, 1, 32'h0000_0000);
      t_wait("pf_data2", 1, 0, 0, 0, 1, 32'hB0B0_B0B0);
      t_wr  ("pf_wr2", 0, 32'h0000_0000, 32'hB0B0_B0B0, 0);
      t_idle("pf_idle", 1, 0, 0, 0, 0, 0, 0);
      // Flush during the prefetch wait: demand word already delivered, prefetch dropped.
      t_idle("pc_miss", 1, 1, 32'h0000_0100, 0, 0, 0, 0);
      t_req ("pc_req", 0, 1, 32'h0000_0100);
      t_wait("pc_data", 1, 0, 0, 0, 1, 32'hC0C0_C0C0);
      t_wr  ("pc_wr", 0, 32'h0000_0100, 32'hC0C0_C0C0, 1);
      t_req ("pc_req2", 0, 1, 32'h0000_0104);
      t_wait("pc_flush", 1, 0, 1, 0, 0, 0);
      t_wait("pc_absorb", 1, 0, 0, 0, 1, 32'hEEEE_EEEE);
      t_idle("pc_idle", 1, 0, 0, 0, 0, 0, 0);
`endif
      // Flush in WR: write still happens, refill_done suppressed (and no prefetch).
      t_idle("fr_miss", 1, 1, 32'h0000_7000, 0, 0, 0, 0);
      t_req ("fr_req", 0, 1, 32'h0000_7000);
      t_wait("fr_data", 1, 0, 0, 0, 1, 32'h7777_7777);
      t_wr  ("fr_wr", 1, 32'h0000_7000, 32'h7777_7777, 0);
      t_idle("fr_idle", 1, 0, 0, 0, 0, 0, 0);
      // Flush in REQ without addr_ok: back to IDLE, no data expected.
      t_idle("fq_miss", 1, 1, 32'h0000_5000, 0, 0, 0, 0);
      t_req ("fq_flush", 1, 0, 32'h0000_5000);
      t_idle("fq_idle", 1, 0, 0, 0, 0, 1, 32'h5555_5555);
      t_idle("fq_idle2", 1, 0, 0, 0, 0, 0, 0);
      // Flush and data_ok in the same WAIT cycle counts as cancelled.
      t_idle("fd_miss", 1, 1, 32'h0000_4000, 0, 0, 0, 0);
      t_req ("fd_req", 0, 1, 32'h0000_4000);
      t_wait("fd_both", 1, 0, 1, 0, 1, 32'h4444_4444);
      t_idle("fd_idle", 1, 0, 0, 0, 0, 0, 0);
      // Miss coincident with flush is not accepted.
      t_idle("mf_miss", 1, 1, 32'h0000_9900, 1, 0, 0, 0);
      t_idle("mf_idle", 1, 0, 0, 0, 0, 0, 0);
      // Reset in WAIT, late data_ok ignored.
      t_idle("rs_miss", 1, 1, 32'h0000_8000, 0, 0, 0, 0);
      t_req ("rs_req", 0, 1, 32'h0000_8000);
      t_wait("rs_reset", 0, 0, 0, 0, 0, 0);
      t_idle("rs_late_dok", 1, 0, 0, 0, 0, 1, 32'h8888_8888);
      t_idle("rs_idle", 1, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      int we_count;
      logic [31:0] first_wpc;
      logic saw_idle;

      drive_idle();
      rst_n = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_state_dbg", -1, {30'd0, state_dbg}, 32'd0);

      build_table();
      for (int i = 0; i < vec_q.size(); i++) begin
         @(negedge clk);
         rst_n        = vec_q[i].rst_n;
         miss_valid   = vec_q[i].mv;
         miss_pc      = vec_q[i].pc;
         flush        = vec_q[i].fl;
         inst_addr_ok = vec_q[i].aok;
         inst_data_ok = vec_q[i].dok;
         inst_rdata   = vec_q[i].rd;
         #1;
         chk({vec_q[i].name, ".inst_req"},    i, {31'd0, inst_req},    {31'd0, vec_q[i].e_req});
         chk({vec_q[i].name, ".inst_addr"},   i, inst_addr,            vec_q[i].e_addr);
         chk({vec_q[i].name, ".cache_we"},    i, {31'd0, cache_we},    {31'd0, vec_q[i].e_we});
         chk({vec_q[i].name, ".cache_wpc"},   i, cache_wpc,            vec_q[i].e_wpc);
         chk({vec_q[i].name, ".cache_winst"}, i, cache_winst,          vec_q[i].e_winst);
         chk({vec_q[i].name, ".refill_done"}, i, {31'd0, refill_done}, {31'd0, vec_q[i].e_done});
         chk({vec_q[i].name, ".refill_inst"}, i, refill_inst,          vec_q[i].e_rinst);
         chk({vec_q[i].name, ".busy"},        i, {31'd0, busy},        {31'd0, vec_q[i].e_busy});
      end

      // Memory always ready: count cache writes for one miss within a bounded window.
      @(negedge clk);
      drive_idle();
      rst_n = 1;
      miss_valid = 1; miss_pc = 32'h0000_9000;
      inst_addr_ok = 1; inst_data_ok = 1; inst_rdata = 32'h9999_0000;
      @(negedge clk);
      miss_valid = 0; miss_pc = 0;
      we_count = 0; first_wpc = 32'hFFFF_FFFF; saw_idle = 0;
      for (int c = 0; c < 12; c++) begin
         #1;
         if (cache_we) begin
            if (we_count == 0) first_wpc = cache_wpc;
            we_count++;
         end
         if (c > 0 && !busy) saw_idle = 1;
         @(negedge clk);
      end
`ifdef ICACHE_REFILL_PREFETCH_EN
      chk("seq.we_count", 0, we_count, 32'd2);
`else
      chk("seq.we_count", 0, we_count, 32'd1);
`endif
      chk("seq.first_wpc", 0, first_wpc, 32'h0000_9000);
      chk("seq.returns_idle", 0, {31'd0, saw_idle}, 32'd1);
      drive_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/icache_refill.md
ICACHE_REFILL -- requirements
Module: icache_refill

Interface
REQ-001 Parameters: none; all address/data widths SHALL be fixed at 32 bits.
REQ-002 clk  input  1  clock; all state SHALL update on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 miss_valid  input  1  fetch stage reports an icache read-port-1 miss this cycle.
REQ-005 miss_pc  input  32  PC of the missing instruction.
REQ-006 flush  input  1  pipeline redirect; cancels the refill in progress.
REQ-007 inst_req  output  1  memory request valid.
REQ-008 inst_addr  output  32  memory request address.
REQ-009 inst_addr_ok  input  1  memory accepted request this cycle.
REQ-010 inst_data_ok  input  1  memory returns read data this cycle.
REQ-011 inst_rdata  input  32  returned instruction word.
REQ-012 cache_we  output  1  icache write enable, one-cycle pulse.
REQ-013 cache_wpc  output  32  PC written as icache tag.
REQ-014 cache_winst  output  32  instruction written as icache data.
REQ-015 refill_done  output  1  demand word available to fetch, one-cycle pulse.
REQ-016 refill_inst  output  32  demand instruction; valid only when refill_done=1.
REQ-017 busy  output  1  refill engine not in IDLE.

Function
REQ-018 FSM states SHALL be IDLE, REQ, WAIT, WR.
REQ-019 IDLE: miss_valid=1 and flush=0 -> latch miss_pc into pc_reg, clear cancel flag, go REQ; otherwise stay.
REQ-020 miss_valid SHALL be ignored in any state other than IDLE.
REQ-021 REQ: inst_req=1, inst_addr=pc_reg; inst_addr_ok=1 -> WAIT.
REQ-022 REQ with flush=1: if inst_addr_ok=1 same cycle -> WAIT with cancel flag set; else -> IDLE, no request issued.
REQ-023 WAIT: inst_req=0; flush=1 SHALL set cancel flag; inst_data_ok=1 -> latch inst_rdata; cancel set -> IDLE with no write; cancel clear -> WR.
REQ-024 Flush and inst_data_ok in the same WAIT cycle SHALL be treated as cancelled (no write).
REQ-025 WR: cache_we=1, cache_wpc=pc_reg, cache_winst=latched data, for exactly one cycle; refill_done=1, refill_inst=latched data in the same cycle for the demand word only.
REQ-026 WR with flush=1 SHALL still write the cache (data is valid) but SHALL suppress refill_done.
REQ-027 inst_addr_ok outside REQ and inst_data_ok outside WAIT SHALL be ignored.
REQ-028 Zero-wait memory latency: miss accepted cycle 0, inst_req cycle 1, data_ok cycle 2, cache_we/refill_done cycle 3, IDLE cycle 4.
REQ-029 At most one outstanding memory request at any time.
REQ-030 busy SHALL be 1 in REQ, WAIT, WR.
REQ-031 cache_wpc, cache_winst, refill_inst SHALL be 0 when their strobe is 0.

Reset
REQ-032 rst_n=0 at a clock edge SHALL force IDLE, clear pc_reg, data register, cancel flag; inst_req, cache_we, refill_done, busy SHALL be 0 on the following cycle.
REQ-033 Reset mid-refill SHALL abandon the transaction; a late inst_data_ok after reset SHALL be ignored (IDLE).

Configuration
REQ-034 Macro ICACHE_REFILL_PREFETCH_EN defined: after WR of the demand word, if flush=0 in WR, pc_reg SHALL advance by 4 (32-bit wrap, 0xFFFF_FFFC -> 0x0000_0000) and the FSM SHALL return to REQ for one sequential word, written via WR with cache_we=1 and refill_done=0; then IDLE.
REQ-035 Prefetch word SHALL obey the same flush/cancel rules; flush during prefetch SHALL not affect the already-delivered demand word.
REQ-036 Macro undefined: WR SHALL always go to IDLE; exactly one cache write per miss.

Verification
REQ-037 Zero-wait: miss_pc=0x1C00_0000, addr_ok cycle 1, data_ok cycle 2 rdata=0x0280_0C0C -> cycle 3 cache_we=1, cache_wpc=0x1C00_0000, cache_winst=0x0280_0C0C, refill_done=1.
REQ-038 Stalled memory: addr_ok withheld 5 cycles, data_ok 3 cycles later -> inst_req held with inst_addr stable, single cache_we, busy=1 throughout.
REQ-039 Flush in WAIT before data_ok -> data_ok absorbed, no cache_we, no refill_done, busy=0 next cycle; new miss then accepted normally.
REQ-040 Flush in REQ without addr_ok -> IDLE next cycle, inst_req=0, no data expected.
REQ-041 Prefetch enabled, miss_pc=0xFFFF_FFFC -> two writes: wpc=0xFFFF_FFFC (refill_done=1) then wpc=0x0000_0000 (refill_done=0).
REQ-042 rst_n=0 in WAIT, data_ok arrives next cycle -> no cache_we, all outputs 0.
